// File: rtl/password_writer.sv
// rtl/password_writer.sv - captures, confirms and programs a new access code into the password storage RAM.
// All outputs are decoded from registered state, so reset clears them without waiting for a clock edge.
module password_writer #(
  parameter int DIGITS  = 4,
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Authenticated,
  input  logic              Change_Req,
  input  logic              Load_Button_PSWD_Game_Control,
  input  logic              Logout_Pulse,
  input  logic [DATA_W-1:0] Data_in,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_WE,
  output logic              Busy,
  output logic              Update_Done,
  output logic              Update_Error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTER   = 3'd1;
  localparam logic [2:0] S_CONFIRM = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DIGITS - 1);
  // Abort fires on the idle edge that would bring the counter to TIMEOUT-1.
  localparam logic [TW-1:0]     TO_LIM   = TW'(TIMEOUT - 2);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              mis_q, mis_d;
  logic              btn_q;
  logic [DATA_W-1:0] dig_q [DIGITS];
  logic [DATA_W-1:0] dig_d [DIGITS];

  logic press;
  logic abort;

  assign press = Load_Button_PSWD_Game_Control & ~btn_q;
  assign abort = Logout_Pulse | ~Authenticated;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    dig_d   = dig_q;
    case (state_q)
      S_IDLE: begin
        if (Change_Req && Authenticated) begin
          state_d = S_ENTER;
          idx_d   = '0;
          cnt_d   = '0;
          mis_d   = 1'b0;
        end
      end
      S_ENTER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (press) begin
          dig_d[idx_q] = Data_in;
          cnt_d        = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_CONFIRM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (cnt_q == TO_LIM) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONFIRM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (press) begin
          cnt_d = '0;
          if (Data_in != dig_q[idx_q]) mis_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (mis_q || (Data_in != dig_q[idx_q])) ? S_ERROR : S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (cnt_q == TO_LIM) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (Change_Req) begin
          state_d = S_ENTER;
          idx_d   = '0;
          cnt_d   = '0;
          mis_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      btn_q   <= 1'b0;
      for (int k = 0; k < DIGITS; k++) dig_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      btn_q   <= Load_Button_PSWD_Game_Control;
      dig_q   <= dig_d;
    end
  end

  assign Mem_WE       = (state_q == S_WRITE);
  assign Mem_Addr     = Mem_WE ? idx_q : '0;
  assign Mem_Data     = Mem_WE ? dig_q[idx_q] : '0;
  assign Busy         = (state_q != S_IDLE);
  assign Update_Done  = (state_q == S_DONE);
  assign Update_Error = (state_q == S_ERROR);

endmodule

// File: tb/tb_password_writer.sv
// tb/tb_password_writer.sv - directed and randomized checks of password_writer against a storage RAM model.
module tb_password_writer;
  localparam int DIGITS  = 4;
  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auth = 1'b0;
  logic chg = 1'b0;
  logic btn = 1'b0;
  logic lo = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mdata;
  logic mwe, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram [DIGITS] = '{default: '0};
  logic [DATA_W-1:0] exp_ram [DIGITS];
  int we_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  password_writer #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Authenticated(auth),
    .Change_Req(chg),
    .Load_Button_PSWD_Game_Control(btn),
    .Logout_Pulse(lo),
    .Data_in(din),
    .Mem_Addr(maddr),
    .Mem_Data(mdata),
    .Mem_WE(mwe),
    .Busy(busy),
    .Update_Done(done),
    .Update_Error(err)
  );

  // Storage RAM the block programs, plus beat and done-pulse counters.
  always @(posedge clk) begin
    if (mwe) begin
      ram[maddr] <= mdata;
      we_cnt <= we_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ram(input string tag);
    for (int k = 0; k < DIGITS; k++)
      chk($sformatf("%s_ram%0d", tag, k), 32'(ram[k]), 32'(exp_ram[k]));
  endtask

  task automatic press(input logic [DATA_W-1:0] d);
    @(negedge clk);
    din = d;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic change();
    @(negedge clk);
    chg = 1'b1;
    @(negedge clk);
    chg = 1'b0;
  endtask

  task automatic logout();
    @(negedge clk);
    lo = 1'b1;
    @(negedge clk);
    lo = 1'b0;
  endtask

  task automatic enter(input logic [15:0] c);
    for (int k = 0; k < DIGITS; k++) press(c[k*4 +: 4]);
  endtask

  // Full change attempt: enter a, confirm b; outcome predicted from a==b alone.
  task automatic txn(input string tag, input logic [15:0] a, input logic [15:0] b, input bit lo_in_write);
    int we0, d0;
    we0 = we_cnt;
    d0  = done_cnt;
    change();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    enter(a);
    enter(b);
    if (a == b) begin
      chk({tag, "_we_lat"}, 32'(mwe), 32'd1);
      for (int i = 1; i <= DIGITS; i++) begin
        @(negedge clk);
        lo = (lo_in_write && i == 1);
      end
      lo = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_we_off"}, 32'(mwe), 32'd0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      for (int k = 0; k < DIGITS; k++) exp_ram[k] = a[k*4 +: 4];
      chk({tag, "_beats"}, 32'(we_cnt - we0), 32'(DIGITS));
      chk({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    end else begin
      chk({tag, "_err"}, 32'(err), 32'd1);
      repeat (3) @(negedge clk);
      chk({tag, "_err_held"}, 32'(err), 32'd1);
      logout();
      chk({tag, "_err_clr"}, 32'(err), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_beats"}, 32'(we_cnt - we0), 32'd0);
      chk({tag, "_ndone"}, 32'(done_cnt - d0), 32'd0);
    end
    chk_ram(tag);
  endtask

  initial begin
    int we0;
    logic [15:0] a, b;
    for (int k = 0; k < DIGITS; k++) exp_ram[k] = '0;

    #3;
    chk("rst_we", 32'(mwe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(maddr), 32'd0);
    chk("rst_data", 32'(mdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    auth = 1'b1;
    @(negedge clk);

    txn("basic", 16'h6964, 16'h6964, 1'b0);
    txn("mism", 16'h4321, 16'h5321, 1'b0);

    // Timeout: 19 idle edges after a press abort to ERROR.
    change();
    press(4'h3);
    repeat (18) @(negedge clk);
    chk("to_pre", 32'(err), 32'd0);
    @(negedge clk);
    chk("to_hit", 32'(err), 32'd1);
    logout();
    chk("to_clr", 32'(busy), 32'd0);

    // A press on the 19th edge wins over the timeout.
    change();
    press(4'h3);
    repeat (17) @(negedge clk);
    press(4'h5);
    chk("to_press_wins_err", 32'(err), 32'd0);
    chk("to_press_wins_busy", 32'(busy), 32'd1);
    logout();
    chk("to_press_wins_idle", 32'(busy), 32'd0);

    // Held button counts once: hold '7' for 10 cycles then finish a matching code.
    we0 = we_cnt;
    change();
    @(negedge clk);
    din = 4'h7;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    din = 4'h0;
    press(4'h1);
    press(4'h2);
    press(4'h8);
    enter(16'h8217);
    repeat (DIGITS + 1) @(negedge clk);
    chk("hold_beats", 32'(we_cnt - we0), 32'(DIGITS));
    exp_ram[0] = 4'h7; exp_ram[1] = 4'h1; exp_ram[2] = 4'h2; exp_ram[3] = 4'h8;
    chk_ram("hold");

    auth = 1'b0;
    change();
    chk("unauth_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("unauth_busy1", 32'(busy), 32'd0);
    auth = 1'b1;

    // Logout coincident with the second confirm press.
    we0 = we_cnt;
    change();
    enter(16'hA5C3);
    press(4'h3);
    @(negedge clk);
    din = 4'hC;
    btn = 1'b1;
    lo = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    lo = 1'b0;
    chk("lo_conf_busy", 32'(busy), 32'd0);
    chk("lo_conf_err", 32'(err), 32'd0);
    repeat (6) @(negedge clk);
    chk("lo_conf_beats", 32'(we_cnt - we0), 32'd0);
    chk_ram("lo_conf");

    txn("lo_write", 16'hB00F, 16'hB00F, 1'b1);

    for (int it = 0; it < 8; it++) begin
      a = 16'($urandom);
      b = a;
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, DIGITS - 1);
        b[k*4 +: 4] = a[k*4 +: 4] ^ 4'($urandom_range(1, 15));
      end
      txn($sformatf("rnd%0d", it), a, b, 1'($urandom_range(0, 1)));
    end

    // Reset during WRITE once beats 0 and 1 are committed.
    we0 = we_cnt;
    change();
    enter(16'h2D91);
    enter(16'h2D91);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_beat2_addr", 32'(maddr), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rstw_we", 32'(mwe), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_addr", 32'(maddr), 32'd0);
    chk("rstw_data", 32'(mdata), 32'd0);
    chk("rstw_done", 32'(done), 32'd0);
    exp_ram[0] = 4'h1; exp_ram[1] = 4'h9;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_idle", 32'(busy), 32'd0);
    chk("rstw_beats", 32'(we_cnt - we0), 32'd2);
    chk_ram("rstw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/password_writer.md
Name: password_writer

Overview:
Programs a new access code into the password storage that the login checker reads. An authenticated user requests a change, enters the new DIGITS-digit code, then re-enters it to confirm. On a match the block writes the digits into the storage RAM through a one-beat-per-cycle write port. On a mismatch, timeout or logout it aborts and writes nothing. It sits beside the password checker and shares its Data_in switches and load button.

Parameters:
DIGITS, 4, number of digits in the code
DATA_W, 4, width of one digit
ADDR_W, 2, storage address width (2**ADDR_W >= DIGITS)
TIMEOUT, 1000, idle cycles allowed between presses in ENTER/CONFIRM before abort (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
Authenticated  input  1  level from password checker; user is logged in
Change_Req  input  1  one-cycle pulse requesting a password change
Load_Button_PSWD_Game_Control  input  1  raw load button level; edge-detected internally
Logout_Pulse  input  1  one-cycle logout request
Data_in  input  DATA_W  digit currently on switches
Mem_Addr  output  ADDR_W  storage write address
Mem_Data  output  DATA_W  storage write data
Mem_WE  output  1  storage write enable
Busy  output  1  high in any state other than IDLE
Update_Done  output  1  one-cycle pulse after a successful write
Update_Error  output  1  held high while in ERROR

Behaviour:
- Reset (asynchronous): state IDLE, digit buffer and counters cleared. Mem_WE, Mem_Addr, Mem_Data, Busy, Update_Done and Update_Error all go to 0 immediately.
- Press detect: a one-cycle press is generated on the first cycle the button is sampled 1 after being sampled 0. The digit is Data_in sampled on that same edge. A held button yields one press.
- States: IDLE, ENTER, CONFIRM, WRITE, DONE, ERROR. Outputs are Moore, decoded from the registered state and counters.
- IDLE: Change_Req while Authenticated=1 moves to ENTER with digit index 0 and timeout counter 0. Change_Req while Authenticated=0 is ignored. Presses in IDLE are ignored.
- ENTER: each press stores the digit into buf[idx] and increments idx. On the DIGITS-th press, move to CONFIRM with idx=0.
- CONFIRM: each press compares Data_in with buf[idx]; any inequality sets a sticky mismatch flag. On the DIGITS-th press, move to WRITE if mismatch=0, else to ERROR.
- Timeout (ENTER/CONFIRM only): the counter increments every cycle without a press and clears on a press. When it reaches TIMEOUT-1 with no press, move to ERROR. A press in the same cycle wins.
- Abort (ENTER/CONFIRM): Logout_Pulse=1 or Authenticated=0 moves to IDLE with no error. This has priority over a press in the same cycle.
- WRITE: lasts exactly DIGITS cycles.
  - Mem_WE=1, Mem_Addr=k, Mem_Data=buf[k] for k=0..DIGITS-1 in order.
  - Uninterruptible except by rst; Logout_Pulse and Change_Req are ignored.
  - Latency: if the final confirm press is sampled on edge n, Mem_WE is high from edge n to edge n+DIGITS.
- DONE: one cycle with Update_Done=1, then IDLE. Logout_Pulse is ignored in this cycle.
- ERROR: Update_Error=1 and Mem_WE=0.
  - Logout_Pulse or Authenticated=0 moves to IDLE.
  - Change_Req moves to ENTER, clearing idx, mismatch and timeout.
- Mem_WE is never 1 outside WRITE. Mem_Addr and Mem_Data are 0 outside WRITE.
- The buffer keeps stale contents after an abort; it is always fully overwritten in ENTER before any use.
- Reset asserted mid-WRITE: the write stops immediately and the partially written storage is accepted as is. No Done pulse is generated.

Test Plan:
- Authenticated=1, Change_Req, presses with Data_in 4,6,9,6 then 4,6,9,6 -> Mem_WE high 4 cycles with (addr,data)=(0,4),(1,6),(2,9),(3,6), then Update_Done pulse for 1 cycle, Busy=0 afterwards.
- Enter 1,2,3,4, confirm 1,2,3,5 -> Update_Error=1 held, Mem_WE never asserted; a following Logout_Pulse -> Update_Error=0, IDLE.
- TIMEOUT=20: Change_Req, one press, then 20 cycles with no press -> ERROR after 19 idle cycles, Update_Error=1; a press landing on cycle 19 instead -> no error.
- Button held high for 10 cycles during ENTER -> exactly one digit stored (idx advances by 1); Change_Req with Authenticated=0 -> Busy stays 0.
- Logout_Pulse coincident with the 2nd CONFIRM press -> IDLE, no write, no error; Logout_Pulse during WRITE -> all 4 beats still issued and Update_Done pulses.
- rst asserted mid-WRITE after beat (1,x) -> Mem_WE=0 without waiting for a clock edge, all outputs 0, state IDLE after release.
